// File: rtl/stream_pkg.sv
// Shared types for the pixel framing path: raw pixel and the tagged FIFO entry.
package stream_pkg;

    localparam int PIX_W = 16;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef struct packed {
        logic   tuser;
        logic   tlast;
        pixel_t data;
    } tagged_pixel_t;

    localparam int TAG_W = $bits(tagged_pixel_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is always visible on rdata.
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
    end

    // Storage array; contents need no reset because empty gates their use.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally modulo DEPTH; occupancy carries one extra bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Status flags and head-of-queue view.
    always_comb begin
        empty = (count_r == {(AW+1){1'b0}});
        full  = (count_r == (AW+1)'(DEPTH));
        rdata = mem_r[rd_ptr_r];
    end

endmodule

// File: rtl/stream_framer.sv
// Tags an unthrottled pixel stream with frame/line markers and buffers it
// toward a backpressured AXI-Stream style sink, flagging any dropped pixel.
module stream_framer
    import stream_pkg::*;
#(
    parameter int LINE_PIXELS = 640,
    parameter int FRAME_LINES = 480,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             s_tvalid,
    input  logic [PIX_W-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [PIX_W-1:0] m_tdata,
    output logic             m_tuser,
    output logic             m_tlast,
    output logic             frame_done,
    output logic             overflow,
    input  logic             ovf_clr
);

    localparam int COL_W = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
    localparam int ROW_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic             overflow_r;
    logic             frame_done_r;

    logic             beat_s;
    logic             col_last_s;
    logic             row_last_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;
    logic             fifo_empty_s;
    logic             fifo_full_s;
    tagged_pixel_t    wr_pix_s;
    tagged_pixel_t    head_s;
    logic [TAG_W-1:0] head_vec_s;

    // Beat qualification, tagging and push/drop decision.
    always_comb begin
        beat_s         = en && s_tvalid;
        col_last_s     = (col_r == COL_W'(LINE_PIXELS - 1));
        row_last_s     = (row_r == ROW_W'(FRAME_LINES - 1));
        wr_pix_s.tuser = (col_r == {COL_W{1'b0}}) && (row_r == {ROW_W{1'b0}});
        wr_pix_s.tlast = col_last_s;
        wr_pix_s.data  = s_tdata;
        pop_s          = !fifo_empty_s && m_tready;
        push_s         = beat_s && (!fifo_full_s || pop_s);
        drop_s         = beat_s && !push_s;
        head_s         = tagged_pixel_t'(head_vec_s);
    end

    // Frame geometry counters; dropped beats still advance them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (!en) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (s_tvalid) begin
            if (col_last_s) begin
                col_r <= {COL_W{1'b0}};
                row_r <= row_last_s ? {ROW_W{1'b0}} : row_r + 1'b1;
            end else begin
                col_r <= col_r + 1'b1;
            end
        end
    end

    // Sticky overflow (a new drop beats a clear) and end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr) begin
                overflow_r <= 1'b0;
            end
            frame_done_r <= beat_s && col_last_s && row_last_s;
        end
    end

    sync_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .wdata (wr_pix_s),
        .pop   (pop_s),
        .rdata (head_vec_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

    // Output view; the stale head is masked whenever nothing is buffered.
    always_comb begin
        m_tvalid   = !fifo_empty_s;
        frame_done = frame_done_r;
        overflow   = overflow_r;
        if (fifo_empty_s) begin
            m_tdata = {PIX_W{1'b0}};
            m_tuser = 1'b0;
            m_tlast = 1'b0;
        end else begin
            m_tdata = head_s.data;
            m_tuser = head_s.tuser;
            m_tlast = head_s.tlast;
        end
    end

endmodule

// File: doc/stream_framer.md
STREAM_FRAMER -- requirements
Module: stream_framer

Interface
REQ-001 Parameter LINE_PIXELS, default 640, SHALL set the number of pixels per line.
REQ-002 Parameter FRAME_LINES, default 480, SHALL set the number of lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 16, power of two and at least 4, SHALL set the number of buffered pixels.
REQ-004 clk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-005 rst_n  in  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-006 en  in  1  SHALL enable frame acquisition; it is the same enable that drives stream_mux.
REQ-007 s_tvalid  in  1  SHALL mark a valid input pixel, driven by stream_mux tvalid_out; there is no input backpressure.
REQ-008 s_tdata  in  16  SHALL carry the input pixel, driven by stream_mux tdata_out.
REQ-009 m_tvalid  out  1  SHALL mark a valid output pixel.
REQ-010 m_tready  in  1  SHALL be the downstream accept signal.
REQ-011 m_tdata  out  16  SHALL carry the output pixel.
REQ-012 m_tuser  out  1  SHALL mark the start of a frame (the pixel at column 0, row 0).
REQ-013 m_tlast  out  1  SHALL mark the end of a line (the pixel at column LINE_PIXELS-1).
REQ-014 frame_done  out  1  SHALL be a one-cycle pulse when the last pixel of a frame is seen at the input.
REQ-015 overflow  out  1  SHALL be a sticky flag for a dropped pixel.
REQ-016 ovf_clr  in  1  SHALL clear overflow synchronously.

Function
REQ-017 An input beat SHALL be counted in every cycle where en and s_tvalid are both 1.
- When en=0: col and row counters reset to 0 synchronously, and no writes occur.
- The FIFO continues to drain while en=0.
REQ-018 Column counter col SHALL advance on each counted beat.
- Wraps from LINE_PIXELS-1 to 0 and increments row.
- row wraps from FRAME_LINES-1 to 0.
REQ-019 Each counted beat SHALL write {tuser=(col==0&&row==0), tlast=(col==LINE_PIXELS-1), s_tdata} into the FIFO when it is not full.
- The write is also allowed when the FIFO is full and a pop occurs in the same cycle.
REQ-020 A counted beat that cannot be written SHALL be dropped and set overflow the next cycle.
- col and row still advance, so frame geometry stays aligned.
REQ-021 ovf_clr and a new overflow in the same cycle SHALL leave overflow set.
REQ-022 The FIFO SHALL be first-word-fall-through.
- m_tvalid = not empty.
- m_tdata, m_tuser and m_tlast show the head entry.
- A pop occurs when m_tvalid && m_tready.
REQ-023 Latency SHALL be one cycle: a pixel written at edge N is presented with m_tvalid=1 after edge N+1, when the FIFO was previously empty.
REQ-024 While m_tvalid=1 and m_tready=0, m_tdata, m_tuser and m_tlast SHALL hold stable.
REQ-025 A simultaneous push and pop SHALL leave the occupancy unchanged, including at the empty and full boundaries.
- A push into an empty FIFO with m_tready=1 is not bypassed; the one-cycle latency still applies.
REQ-026 frame_done SHALL pulse for one cycle after the counted beat at col=LINE_PIXELS-1, row=FRAME_LINES-1, whether or not that beat was dropped.
REQ-027 Occupancy arithmetic SHALL use log2(FIFO_DEPTH)+1 bits; the read and write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-028 While rst_n=0, the block SHALL hold the following:
- m_tvalid=0, m_tuser=0, m_tlast=0, m_tdata=16'h0000;
- frame_done=0, overflow=0;
- col=0, row=0;
- FIFO empty.
REQ-029 A reset asserted mid-frame SHALL discard all buffered pixels; after release, the next counted beat is tagged tuser=1.

Structure
REQ-030 Package stream_pkg SHALL hold the following:
- PIX_W=16;
- typedef pixel_t (logic[15:0]);
- the packed struct tagged_pixel_t {tuser, tlast, pixel_t data}.
REQ-031 The FIFO SHALL be a separate sub-module sync_fifo, parameterised by width and depth, with the same clk/rst_n.
- Tagging, counters and status logic reside in stream_framer.

Verification
REQ-032 Frame: with LINE_PIXELS=4, FRAME_LINES=2, en=1, s_tvalid held high for 8 cycles with data 16'h0001..16'h0008, and m_tready=1, the bench SHALL observe the following:
- outputs 0001..0008 in order;
- tuser on 0001 only;
- tlast on 0004 and 0008;
- frame_done pulses once, after the 0008 beat.
REQ-033 Backpressure: with m_tready=0 and 20 beats into FIFO_DEPTH=16, the bench SHALL observe the following:
- the first 16 are kept and 4 dropped;
- overflow=1 from the cycle after the 17th beat;
- after m_tready=1, exactly 16 pixels emerge in order.
REQ-034 Full boundary: with the FIFO full, a simultaneous push and pop SHALL leave it full with no overflow, and the new pixel SHALL appear last.
REQ-035 en toggle: dropping en mid-line after 2 beats, then re-raising it SHALL tag the next beat tuser=1, with col restarting at 0.
REQ-036 Reset mid-operation: pulsing rst_n low with 5 pixels buffered SHALL give m_tvalid=0 immediately (asynchronous), overflow=0, and the first pixel after release tagged tuser=1.
REQ-037 ovf_clr: pulsing ovf_clr with no new drop SHALL clear overflow next cycle; ovf_clr coincident with a drop SHALL keep overflow=1.
